// File: rtl/osd_fb_pkg.sv
// Shared types and constants for the OSD framebuffer responder.
// Holds the pixel packing constants, response codes and the parked-write entry.
package osd_fb_pkg;
  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_DECODEERROR = 2'b11;
  localparam int FB_WORD_W    = 32;
  localparam int PIX_BITS     = 2;
  localparam int PIX_PER_WORD = FB_WORD_W / PIX_BITS;

  // Index is sized for the largest possible word address; unused upper bits stay zero.
  typedef struct packed {
    logic [29:0]          idx;
    logic [FB_WORD_W-1:0] data;
    logic [3:0]           be;
  } osd_fb_wr_t;

  function automatic logic [FB_WORD_W-1:0] merge_bytes(input logic [FB_WORD_W-1:0] base,
                                                       input logic [FB_WORD_W-1:0] over,
                                                       input logic [3:0]           be);
    logic [FB_WORD_W-1:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = over[8*b +: 8];
      end else begin
        res[8*b +: 8] = base[8*b +: 8];
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/osd_fb_ram.sv
// Single-port framebuffer RAM with byte-lane writes and a registered read port.
// Read-first: rdata reflects the word before a same-cycle write.
module osd_fb_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  // Byte-masked write and registered read on the shared address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/osd_fb_responder.sv
// OSD framebuffer responder: real-time read port with priority over a CPU write
// port; colliding CPU writes park in a one-entry hold that reads bypass through.
module osd_fb_responder
  import osd_fb_pkg::*;
#(
  parameter int FB_WORDS = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] rd_address,
  input  logic        rd_read,
  output logic        rd_waitrequest,
  output logic [31:0] rd_readdata,
  output logic        rd_readdatavalid,
  output logic [1:0]  rd_response,
  input  logic        wr_chipselect,
  input  logic        wr_write,
  input  logic [31:0] wr_address,
  input  logic [31:0] wr_writedata,
  input  logic [3:0]  wr_byteenable,
  output logic        wr_waitrequest_n,
  output logic        fb_err
);
  localparam int ADDR_W = $clog2(FB_WORDS);

  logic [ADDR_W-1:0] rd_idx, wr_idx, ram_addr;
  logic              rd_oor, wr_oor, wr_req, wr_take, wr_live, cap, drain;
  logic              hold_empty;
  osd_fb_wr_t        hold;
  logic              ram_we;
  logic [3:0]        ram_be, byp_be, s1_byp_be;
  logic [31:0]       ram_wdata, ram_rdata, byp_data, s1_byp_data;
  logic              s1_valid, s1_oor;
  logic              unused_addr_bits;

  assign rd_idx           = rd_address[ADDR_W+1:2];
  assign wr_idx           = wr_address[ADDR_W+1:2];
  assign rd_oor           = |rd_address[31:ADDR_W+2];
  assign wr_oor           = |wr_address[31:ADDR_W+2];
  assign unused_addr_bits = ^{rd_address[1:0], wr_address[1:0]};
  assign wr_req           = wr_chipselect & wr_write;
  assign wr_take          = wr_req & hold_empty;
  // A taken write that actually changes RAM: in range with at least one lane.
  assign wr_live          = wr_take & ~wr_oor & (wr_byteenable != 4'b0000);
  assign cap              = wr_live & rd_read;
  assign drain            = ~hold_empty & ~rd_read;
  assign rd_waitrequest   = 1'b0;
  assign wr_waitrequest_n = hold_empty;

  osd_fb_ram #(.DEPTH(FB_WORDS), .AW(ADDR_W)) u_ram (
    .clk   (clk_i),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM port arbitration: read, then hold drain, then direct CPU commit.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'b0000;
    ram_addr  = rd_idx;
    ram_wdata = 32'h0000_0000;
    if (rst_i) begin
      ram_we = 1'b0;
    end else if (rd_read) begin
      ram_addr = rd_idx;
    end else if (!hold_empty) begin
      ram_we    = 1'b1;
      ram_be    = hold.be;
      ram_addr  = hold.idx[ADDR_W-1:0];
      ram_wdata = hold.data;
    end else if (wr_live) begin
      ram_we    = 1'b1;
      ram_be    = wr_byteenable;
      ram_addr  = wr_idx;
      ram_wdata = wr_writedata;
    end else begin
      ram_we = 1'b0;
    end
  end

  // Bypass source for the read: the parked write, or the one being parked now.
  always_comb begin
    byp_be   = 4'b0000;
    byp_data = 32'h0000_0000;
    if (!hold_empty && hold.idx == 30'(rd_idx)) begin
      byp_be   = hold.be;
      byp_data = hold.data;
    end else if (cap && wr_idx == rd_idx) begin
      byp_be   = wr_byteenable;
      byp_data = wr_writedata;
    end else begin
      byp_be = 4'b0000;
    end
  end

  // Hold register and sticky decode-error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_empty <= 1'b1;
      hold       <= '0;
      fb_err     <= 1'b0;
    end else begin
      if (drain) begin
        hold_empty <= 1'b1;
      end else if (cap) begin
        hold_empty <= 1'b0;
        hold.idx   <= 30'(wr_idx);
        hold.data  <= wr_writedata;
        hold.be    <= wr_byteenable;
      end
      if (wr_take && wr_oor) begin
        fb_err <= 1'b1;
      end
    end
  end

  // Read pipeline: RAM register, then merge/output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid         <= 1'b0;
      s1_oor           <= 1'b0;
      s1_byp_be        <= 4'b0000;
      s1_byp_data      <= 32'h0000_0000;
      rd_readdatavalid <= 1'b0;
      rd_readdata      <= 32'h0000_0000;
      rd_response      <= RESP_OKAY;
    end else begin
      s1_valid         <= rd_read;
      s1_oor           <= rd_oor;
      s1_byp_be        <= byp_be;
      s1_byp_data      <= byp_data;
      rd_readdatavalid <= s1_valid;
      if (s1_valid && !s1_oor) begin
        rd_readdata <= merge_bytes(ram_rdata, s1_byp_data, s1_byp_be);
        rd_response <= RESP_OKAY;
      end else if (s1_valid) begin
        rd_readdata <= 32'h0000_0000;
        rd_response <= RESP_DECODEERROR;
      end else begin
        rd_readdata <= 32'h0000_0000;
        rd_response <= RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_osd_fb_responder.sv
// Self-checking bench for osd_fb_responder: directed scenarios plus random traffic
// checked against a logical-memory model with a queue of expected read returns.
module tb_osd_fb_responder;
  logic        clk_i = 1'b0;
  logic        rst_i, rd_read, rd_waitrequest, rd_readdatavalid;
  logic [31:0] rd_address, rd_readdata, wr_address, wr_writedata;
  logic [1:0]  rd_response;
  logic        wr_chipselect, wr_write, wr_waitrequest_n, fb_err;
  logic [3:0]  wr_byteenable;

  always #5 clk_i = ~clk_i;

  osd_fb_responder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_address(rd_address), .rd_read(rd_read), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid), .rd_response(rd_response),
    .wr_chipselect(wr_chipselect), .wr_write(wr_write), .wr_address(wr_address),
    .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
    .wr_waitrequest_n(wr_waitrequest_n), .fb_err(fb_err)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] view_m [4096];   // what every read must see (all accepted writes)
  logic [31:0] ram_m  [4096];   // what survives a reset (committed writes only)
  bit          pend_m;          // an accepted write not yet committed
  int          pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_be;
  bit          err_m, acc_last;
  int          cnt, checks, passes;

  function automatic logic [31:0] apply_be(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cnt);
  endtask

  task automatic drive(bit rd, logic [31:0] ra, bit w, logic [31:0] wa, logic [31:0] wd, logic [3:0] be);
    rd_read = rd; rd_address = ra;
    wr_chipselect = w; wr_write = w; wr_address = wa; wr_writedata = wd; wr_byteenable = be;
  endtask

  // One clock: check ready, update the model from the spec rules, clock, check outputs.
  task automatic tick();
    exp_t e;
    bit   w, roor, woor;
    int   ridx, widx;
    w    = wr_chipselect & wr_write;
    roor = |rd_address[31:14];
    woor = |wr_address[31:14];
    ridx = int'(rd_address[13:2]);
    widx = int'(wr_address[13:2]);
    acc_last = 1'b0;
    if (rst_i) begin
      q.delete();
      pend_m = 1'b0;
      err_m  = 1'b0;
      for (int i = 0; i < 4096; i++) view_m[i] = ram_m[i];
    end else begin
      chk("wr_waitrequest_n", 32'(wr_waitrequest_n), 32'(!pend_m));
      chk("rd_waitrequest", 32'(rd_waitrequest), 32'd0);
      if (pend_m) begin
        if (!rd_read) begin
          ram_m[pend_idx] = apply_be(ram_m[pend_idx], pend_data, pend_be);
          pend_m = 1'b0;
        end
      end else if (w) begin
        acc_last = 1'b1;
        if (woor) begin
          err_m = 1'b1;
        end else if (wr_byteenable != 4'b0000) begin
          view_m[widx] = apply_be(view_m[widx], wr_writedata, wr_byteenable);
          if (rd_read) begin
            pend_m = 1'b1; pend_idx = widx; pend_data = wr_writedata; pend_be = wr_byteenable;
          end else begin
            ram_m[widx] = apply_be(ram_m[widx], wr_writedata, wr_byteenable);
          end
        end
      end
      if (rd_read) begin
        e.due  = cnt + 2;
        e.data = roor ? 32'h0 : view_m[ridx];
        e.resp = roor ? 2'b11 : 2'b00;
        q.push_back(e);
      end
    end
    @(posedge clk_i);
    #1;
    cnt++;
    if (q.size() > 0 && q[0].due == cnt) begin
      e = q.pop_front();
      chk("rd_readdatavalid", 32'(rd_readdatavalid), 32'd1);
      chk("rd_readdata", rd_readdata, e.data);
      chk("rd_response", 32'(rd_response), 32'(e.resp));
    end else begin
      chk("rd_readdatavalid_idle", 32'(rd_readdatavalid), 32'd0);
    end
    chk("fb_err", 32'(fb_err), 32'(err_m));
  endtask

  task automatic idle(int n);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit          have_w;
    logic [31:0] pa, pd;
    logic [3:0]  pb;
    cnt = 0; checks = 0; passes = 0; pend_m = 1'b0; err_m = 1'b0;
    for (int i = 0; i < 4096; i++) begin view_m[i] = 32'h0; ram_m[i] = 32'h0; end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk("reset_readdata", rd_readdata, 32'h0);
    chk("reset_response", 32'(rd_response), 32'd0);
    chk("reset_ready", 32'(wr_waitrequest_n), 32'd1);

    // Preload the first 64 words so every later read has defined contents.
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'(4*i), $urandom, 4'hF);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0,  32'h11111111, 4'hF); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h4,  32'h22222222, 4'hF); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h8,  32'h33333333, 4'hF); tick();
    drive(1'b0, 32'h0, 1'b1, 32'h10, 32'h00000000, 4'hF); tick();

    // Streaming reads of three preloaded words.
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    drive(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(3);

    // Out-of-range read, then word 0 still intact.
    drive(1'b1, 32'h00004000, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(2);
    drive(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(2);

    // Write colliding with a read of the same word: bypass, then drain.
    drive(1'b1, 32'h10, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101); tick();
    chk("bypass_hold_taken", 32'(acc_last), 32'd1);
    idle(1);
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(2);

    // Continuous reads starve a second write; it lands after the first idle drain.
    drive(1'b1, 32'(4 * $urandom_range(0, 63)), 1'b1, 32'h20, 32'hCAFEF00D, 4'hF); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(4 * $urandom_range(0, 63)), 1'b1, 32'h24, 32'h5EED1234, 4'hF);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h24, 32'h5EED1234, 4'hF); tick();
    tick();
    chk("second_write_taken", 32'(acc_last), 32'd1);
    drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    drive(1'b1, 32'h24, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(2);

    // Random traffic; a stalled write is held until accepted.
    have_w = 1'b0; pa = 32'h0; pd = 32'h0; pb = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if (!have_w && $urandom_range(0, 2) == 0) begin
        have_w = 1'b1;
        pa = ($urandom_range(0, 15) == 0) ? 32'h00010000 + 32'(4 * $urandom_range(0, 7))
                                          : 32'(4 * $urandom_range(0, 63));
        pd = $urandom;
        pb = 4'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 15) == 0) ? 32'h00004000 + 32'(4 * $urandom_range(0, 7))
                                         : 32'(4 * $urandom_range(0, 63)) | 32'($urandom_range(0, 3)),
            have_w, pa, pd, pb);
      tick();
      if (acc_last) have_w = 1'b0;
    end
    idle(3);
    rst_i = 1'b1; tick(); rst_i = 1'b0;

    // Out-of-range write sets the sticky error until reset.
    drive(1'b0, 32'h0, 1'b1, 32'h00010000, 32'hDEADBEEF, 4'hF); tick();
    idle(4);
    chk("fb_err_sticky", 32'(fb_err), 32'd1);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    idle(1);
    chk("fb_err_cleared", 32'(fb_err), 32'd0);

    // Reset right after a read: no return, and the parked write is lost.
    drive(1'b1, 32'h30, 1'b1, 32'h30, 32'h12345678, 4'hF); tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    idle(3);
    drive(1'b1, 32'h30, 1'b0, 32'h0, 32'h0, 4'h0); tick();
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
